// File: rtl/note_slave.sv
`default_nettype none
// ============================================================================
//  Module      : note_slave
//  Description : Write-only bus slave with independent address and data
//                channels and a registered write response. It feeds a
//                2^ADDR_W x DATA_W register file. The file has one
//                combinational local read port.
//  Ports       : clk, reset                - clock, async active-high reset
//                AWADDR/AWVALID/AWREADY    - write address channel
//                WDATA/WVALID/WREADY       - write data channel
//                BVALID/BREADY             - write response channel
//                rd_addr/rd_data           - local combinational read port
//                wr_strobe/wr_addr/wr_data - notification of completed write
//  Revision    : 1.0 - initial release
// ============================================================================
module note_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_ADDR = 2'd1,
    GOT_DATA = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_awready, r_wready, r_bvalid, r_strobe;
  logic              w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_strobe_nxt;
  logic [ADDR_W-1:0] r_addr_hold, r_wr_addr;
  logic [DATA_W-1:0] r_data_hold, r_wr_data;
  logic [DATA_W-1:0] r_mem [c_DEPTH];

  logic              w_aw_hs, w_w_hs;
  logic              w_latch_addr, w_latch_data, w_do_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // Handshakes use the registered READY values that the master sees.
  assign w_aw_hs = AWVALID & r_awready;
  assign w_w_hs  = WVALID  & r_wready;

  always_comb begin
    w_state_nxt   = r_state;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    w_strobe_nxt  = 1'b0;
    w_latch_addr  = 1'b0;
    w_latch_data  = 1'b0;
    w_do_write    = 1'b0;
    // The channel that completes on this edge takes its value from the bus.
    // The other channel takes its value from the holding register.
    w_sel_addr    = r_addr_hold;
    w_sel_data    = r_data_hold;

    case (r_state)
      IDLE: begin
        w_awready_nxt = 1'b1;
        w_wready_nxt  = 1'b1;
        if (w_aw_hs && w_w_hs) begin
          w_do_write    = 1'b1;
          w_sel_addr    = AWADDR;
          w_sel_data    = WDATA;
          w_state_nxt   = RESP;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
          w_bvalid_nxt  = 1'b1;
          w_strobe_nxt  = 1'b1;
        end else if (w_aw_hs) begin
          w_latch_addr  = 1'b1;
          w_state_nxt   = GOT_ADDR;
          w_awready_nxt = 1'b0;
        end else if (w_w_hs) begin
          w_latch_data  = 1'b1;
          w_state_nxt   = GOT_DATA;
          w_wready_nxt  = 1'b0;
        end
      end

      GOT_ADDR: begin
        w_wready_nxt = 1'b1;
        if (w_w_hs) begin
          w_do_write   = 1'b1;
          w_sel_data   = WDATA;
          w_state_nxt  = RESP;
          w_wready_nxt = 1'b0;
          w_bvalid_nxt = 1'b1;
          w_strobe_nxt = 1'b1;
        end
      end

      GOT_DATA: begin
        w_awready_nxt = 1'b1;
        if (w_aw_hs) begin
          w_do_write    = 1'b1;
          w_sel_addr    = AWADDR;
          w_state_nxt   = RESP;
          w_awready_nxt = 1'b0;
          w_bvalid_nxt  = 1'b1;
          w_strobe_nxt  = 1'b1;
        end
      end

      RESP: begin
        w_bvalid_nxt = 1'b1;
        if (r_bvalid && BREADY) begin
          w_state_nxt   = IDLE;
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_strobe    <= 1'b0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_strobe  <= w_strobe_nxt;
      if (w_latch_addr) begin
        r_addr_hold <= AWADDR;
      end
      if (w_latch_data) begin
        r_data_hold <= WDATA;
      end
      if (w_do_write) begin
        r_mem[w_sel_addr] <= w_sel_data;
        r_wr_addr         <= w_sel_addr;
        r_wr_data         <= w_sel_data;
      end
    end
  end

  assign AWREADY   = r_awready;
  assign WREADY    = r_wready;
  assign BVALID    = r_bvalid;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_data   = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_note_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_slave
//  Description : Self-checking bench for note_slave. It runs directed
//                scenarios, then random traffic. Each cycle is compared
//                against a transaction-level model. The model tracks
//                which channels have been collected and whether a
//                response is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] AWADDR;
  logic       AWVALID;
  logic       AWREADY;
  logic [6:0] WDATA;
  logic       WVALID;
  logic       WREADY;
  logic       BVALID;
  logic       BREADY;
  logic [3:0] rd_addr;
  logic [6:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [6:0] wr_data;

  note_slave #(.ADDR_W(4), .DATA_W(7)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Transaction-level reference model.
  bit       m_awready, m_wready, m_bvalid, m_strobe;
  bit       m_has_a, m_has_d, m_resp;
  bit [3:0] m_a, m_wa;
  bit [6:0] m_d, m_wd;
  bit [6:0] m_mem [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_strobe = 0;
    m_has_a = 0; m_has_d = 0; m_resp = 0;
    m_a = 0; m_d = 0; m_wa = 0; m_wd = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    bit aw, w;
    aw = AWVALID && m_awready;
    w  = WVALID && m_wready;
    m_strobe = 0;
    if (m_resp) begin
      if (BREADY) begin
        m_resp = 0; m_bvalid = 0; m_awready = 1; m_wready = 1;
      end
    end else begin
      if (aw) begin m_has_a = 1; m_a = AWADDR; end
      if (w)  begin m_has_d = 1; m_d = WDATA;  end
      if (m_has_a && m_has_d) begin
        m_mem[m_a] = m_d;
        m_wa = m_a; m_wd = m_d;
        m_has_a = 0; m_has_d = 0;
        m_resp = 1; m_bvalid = 1; m_strobe = 1;
        m_awready = 0; m_wready = 0;
      end else begin
        m_awready = !m_has_a;
        m_wready  = !m_has_d;
      end
    end
  endtask

  task automatic check_outputs();
    chk("awready", AWREADY, m_awready);
    chk("wready", WREADY, m_wready);
    chk("bvalid", BVALID, m_bvalid);
    chk("wr_strobe", wr_strobe, m_strobe);
    chk("wr_addr", wr_addr, m_wa);
    chk("wr_data", wr_data, m_wd);
    rd_addr = 4'($urandom);
    #1;
    chk("rd_data", rd_data, m_mem[rd_addr]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [6:0] exp);
    rd_addr = a;
    #1;
    chk("rd_direct", rd_data, exp);
  endtask

  // Asserts reset between edges. Outputs must clear at once, without
  // waiting for an edge. Reset is released one edge later.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_bvalid", BVALID, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_strobe", wr_strobe, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  int strobes;
  int idx;

  initial begin
    reset = 1'b1; AWADDR = 0; AWVALID = 0; WDATA = 0; WVALID = 0;
    BREADY = 0; rd_addr = 0;
    #2;
    apply_reset();
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    for (int i = 0; i < 16; i++) read_chk(4'(i), 7'h00);
    step();
    chk("ready_after_rst", {AWREADY, WREADY}, 2'b11);

    // Simultaneous address and data.
    AWADDR = 4'd3; WDATA = 7'h45; AWVALID = 1; WVALID = 1; BREADY = 1;
    step();
    chk("sim_bvalid", BVALID, 1);
    chk("sim_strobe", wr_strobe, 1);
    AWVALID = 0; WVALID = 0;
    read_chk(4'd3, 7'h45);
    step();
    chk("sim_ready_back", {AWREADY, WREADY}, 2'b11);

    // Address first, data three cycles later. A changing AWADDR with
    // AWVALID still high must not replace the held address.
    AWADDR = 4'd9; AWVALID = 1;
    step();
    AWADDR = 4'd5;
    repeat (3) begin
      step();
      chk("af_awready_low", AWREADY, 0);
    end
    AWVALID = 0; WDATA = 7'h12; WVALID = 1;
    step();
    chk("af_strobe", wr_strobe, 1);
    chk("af_wr_addr", wr_addr, 9);
    WVALID = 0;
    strobes = 0;
    repeat (3) begin
      step();
      if (wr_strobe) strobes++;
    end
    chk("af_single_strobe", strobes, 0);
    read_chk(4'd9, 7'h12);
    read_chk(4'd5, 7'h00);

    // Data first, address two cycles later.
    WDATA = 7'h7F; WVALID = 1;
    step();
    WDATA = 7'h11;
    step();
    AWADDR = 4'd15; AWVALID = 1;
    step();
    chk("df_wr_addr", wr_addr, 15);
    chk("df_wr_data", wr_data, 7'h7F);
    AWVALID = 0; WVALID = 0;
    read_chk(4'd15, 7'h7F);
    step();

    // Response back-pressure.
    BREADY = 0; AWADDR = 4'd5; WDATA = 7'h2A; AWVALID = 1; WVALID = 1;
    step();
    WVALID = 0; AWADDR = 4'd6;
    repeat (5) begin
      step();
      chk("bp_bvalid_held", BVALID, 1);
      chk("bp_readys_low", {AWREADY, WREADY}, 2'b00);
    end
    AWVALID = 0; BREADY = 1;
    step();
    chk("bp_bvalid_drop", BVALID, 0);
    read_chk(4'd6, 7'h00);
    read_chk(4'd5, 7'h2A);

    // Reset while holding a latched address.
    AWADDR = 4'd2; AWVALID = 1;
    step();
    AWVALID = 0;
    step();
    apply_reset();
    step();
    chk("rga_readys", {AWREADY, WREADY}, 2'b11);
    chk("rga_no_strobe", wr_strobe, 0);
    read_chk(4'd2, 7'h00);

    // Reset while a response is outstanding: BVALID must fall at once.
    BREADY = 0; AWADDR = 4'd7; WDATA = 7'h33; AWVALID = 1; WVALID = 1;
    step();
    AWVALID = 0; WVALID = 0;
    step();
    apply_reset();
    step();

    // Streaming: sixteen writes back to back.
    BREADY = 1; AWVALID = 1; WVALID = 1; idx = 0; strobes = 0;
    AWADDR = 4'd0; WDATA = 7'd1;
    for (int c = 0; c < 32; c++) begin
      step();
      if (wr_strobe) begin strobes++; idx++; end
      if (idx < 16) begin
        AWADDR = 4'(idx); WDATA = 7'(idx + 1);
      end else begin
        AWVALID = 0; WVALID = 0;
      end
    end
    chk("stream_strobes", strobes, 16);
    chk("stream_idle", {AWREADY, WREADY, BVALID}, 3'b110);
    for (int i = 0; i < 16; i++) read_chk(4'(i), 7'(i + 1));

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      AWVALID = 1'($urandom);
      WVALID  = 1'($urandom);
      BREADY  = ($urandom_range(3) != 0);
      AWADDR  = 4'($urandom);
      WDATA   = 7'($urandom);
      if ($urandom_range(63) == 0) apply_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
